// File: rtl/gnr_pkg.sv
// Shared types and default sizing for the GNR attractor sequencer.
package gnr_pkg;

    localparam int N_NODES_DEF   = 8;
    localparam int CNT_W_DEF     = 32;
    localparam int MAX_STEPS_DEF = 1000000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        CMP,
        PSTEP,
        PCMP,
        REPORT,
        FIN
    } gnr_state_e;

endpackage

// File: rtl/gnr_res_reg.sv
// Result holding register: captures one attractor result and offers it over valid/ready.
module gnr_res_reg
    import gnr_pkg::*;
#(
    parameter int N_NODES = N_NODES_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [N_NODES-1:0] init_i,
    input  logic [CNT_W-1:0]   steps_i,
    input  logic [CNT_W-1:0]   period_i,
    input  logic               timeout_i,
    input  logic               res_ready,
    output logic               res_valid,
    output logic [N_NODES-1:0] res_init,
    output logic [CNT_W-1:0]   res_steps,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout,
    output logic               accept_o
);

    logic               valid_q;
    logic [N_NODES-1:0] init_q;
    logic [CNT_W-1:0]   steps_q;
    logic [CNT_W-1:0]   period_q;
    logic               timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            init_q    <= '0;
            steps_q   <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            init_q    <= init_i;
            steps_q   <= steps_i;
            period_q  <= period_i;
            timeout_q <= timeout_i;
        end else if (valid_q && res_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign res_valid   = valid_q;
    assign res_init    = init_q;
    assign res_steps   = steps_q;
    assign res_period  = period_q;
    assign res_timeout = timeout_q;
    assign accept_o    = valid_q && res_ready;

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Floyd-style attractor search sequencer driving a GNR node array.
// States: IDLE wait start | LOAD node load | STEP both step | CMP meet check | PSTEP hare step | PCMP period check | REPORT result out | FIN done pulse
module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int N_NODES   = N_NODES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_STEPS = MAX_STEPS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_base,
    input  logic [N_NODES-1:0] init_count,
    input  logic [N_NODES-1:0] net_s0,
    input  logic [N_NODES-1:0] net_s1,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [CNT_W-1:0]   res_steps,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);

    gnr_state_e         state_q;
    logic [N_NODES-1:0] cur_q;
    logic [N_NODES-1:0] rem_q;
    logic [N_NODES-1:0] init_state_q;
    logic [CNT_W-1:0]   steps_q;
    logic [CNT_W-1:0]   period_q;
    logic               reset_nos_q;
    logic               start_s0_q;
    logic               start_s1_q;
    logic               busy_q;
    logic               done_q;

    logic               meet_d;
    logic               to_report_d;
    logic               tmo_d;
    logic               accept_d;
    logic [N_NODES-1:0] cur_nxt_d;
    logic [N_NODES-1:0] rem_nxt_d;

    // The result register captures on the same edge the FSM enters REPORT.
    always_comb begin
        meet_d      = (net_s0 == net_s1);
        to_report_d = 1'b0;
        tmo_d       = 1'b0;
        cur_nxt_d   = cur_q + N_NODES'(1);
        rem_nxt_d   = rem_q - N_NODES'(1);
        case (state_q)
            CMP: begin
                if (!meet_d && steps_q == MAX_C) begin
                    to_report_d = 1'b1;
                    tmo_d       = 1'b1;
                end
            end
            PCMP: begin
                if (meet_d) begin
                    to_report_d = 1'b1;
                end else if (period_q == MAX_C) begin
                    to_report_d = 1'b1;
                    tmo_d       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            rem_q        <= '0;
            init_state_q <= '0;
            steps_q      <= '0;
            period_q     <= '0;
            reset_nos_q  <= 1'b0;
            start_s0_q   <= 1'b0;
            start_s1_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            reset_nos_q <= 1'b0;
            start_s0_q  <= 1'b0;
            start_s1_q  <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_q <= init_base;
                        rem_q <= init_count;
                        if (init_count == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= LOAD;
                            busy_q       <= 1'b1;
                            reset_nos_q  <= 1'b1;
                            init_state_q <= init_base;
                            steps_q      <= '0;
                            period_q     <= '0;
                        end
                    end
                end
                LOAD: begin
                    state_q    <= STEP;
                    start_s0_q <= 1'b1;
                    start_s1_q <= 1'b1;
                    steps_q    <= (steps_q == MAX_C) ? MAX_C : steps_q + CNT_W'(1);
                end
                STEP: state_q <= CMP;
                CMP: begin
                    if (meet_d) begin
                        state_q    <= PSTEP;
                        start_s1_q <= 1'b1;
                        period_q   <= (period_q == MAX_C) ? MAX_C : period_q + CNT_W'(1);
                    end else if (to_report_d) begin
                        state_q <= REPORT;
                    end else begin
                        state_q    <= STEP;
                        start_s0_q <= 1'b1;
                        start_s1_q <= 1'b1;
                        steps_q    <= (steps_q == MAX_C) ? MAX_C : steps_q + CNT_W'(1);
                    end
                end
                PSTEP: state_q <= PCMP;
                PCMP: begin
                    if (to_report_d) begin
                        state_q <= REPORT;
                    end else begin
                        state_q    <= PSTEP;
                        start_s1_q <= 1'b1;
                        period_q   <= (period_q == MAX_C) ? MAX_C : period_q + CNT_W'(1);
                    end
                end
                REPORT: begin
                    if (accept_d) begin
                        cur_q <= cur_nxt_d;
                        rem_q <= rem_nxt_d;
                        if (rem_nxt_d != '0) begin
                            state_q      <= LOAD;
                            reset_nos_q  <= 1'b1;
                            init_state_q <= cur_nxt_d;
                            steps_q      <= '0;
                            period_q     <= '0;
                        end else begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    gnr_res_reg #(
        .N_NODES (N_NODES),
        .CNT_W   (CNT_W)
    ) u_res_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (to_report_d),
        .init_i      (cur_q),
        .steps_i     (steps_q),
        .period_i    (period_q),
        .timeout_i   (tmo_d),
        .res_ready   (res_ready),
        .res_valid   (res_valid),
        .res_init    (res_init),
        .res_steps   (res_steps),
        .res_period  (res_period),
        .res_timeout (res_timeout),
        .accept_o    (accept_d)
    );

    assign reset_nos  = reset_nos_q;
    assign init_state = init_state_q;
    assign start_s0   = start_s0_q;
    assign start_s1   = start_s1_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Randomised bench: node-array model plus a trajectory-level reference for each initial state.
module tb_gnr_attractor_ctrl;

    localparam int N    = 8;
    localparam int CW   = 32;
    localparam int MAXS = 16;

    typedef struct {
        logic [N-1:0]  init;
        logic [CW-1:0] steps;
        logic [CW-1:0] period;
        logic          tmo;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          res_ready = 1'b0;
    logic [N-1:0]  init_base = '0;
    logic [N-1:0]  init_count = '0;
    logic [N-1:0]  net_s0 = '0;
    logic [N-1:0]  net_s1 = '0;
    logic          reset_nos, start_s0, start_s1, busy, done, res_valid, res_timeout;
    logic [N-1:0]  init_state, res_init;
    logic [CW-1:0] res_steps, res_period;

    gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(MAXS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .init_base   (init_base),
        .init_count  (init_count),
        .net_s0      (net_s0),
        .net_s1      (net_s1),
        .reset_nos   (reset_nos),
        .init_state  (init_state),
        .start_s0    (start_s0),
        .start_s1    (start_s1),
        .busy        (busy),
        .done        (done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_init    (res_init),
        .res_steps   (res_steps),
        .res_period  (res_period),
        .res_timeout (res_timeout)
    );

    always #5 clk = ~clk;

    int         mode = 0;
    int         rdy_mode = 0;
    logic [N-1:0] tab [256];
    logic       par = 1'b0;

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, load_cyc = 0, last_lat = 0;
    int   n_done = 0, n_res = 0, n_load = 0, hold = 0;
    logic prev_valid = 1'b0;
    res_t exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // 0 identity, 1 3-bit ring rotator on the low bits, 2 8-bit counter, 3 random map
    function automatic logic [N-1:0] nf(input logic [N-1:0] x);
        case (mode)
            0:       return x;
            1:       return {x[7:3], x[1:0], x[2]};
            2:       return x + 8'd1;
            default: return tab[x];
        endcase
    endfunction

    function automatic res_t ref_result(input logic [N-1:0] x);
        res_t r;
        logic [N-1:0] t, h;
        bit met;
        r.init = x; r.tmo = 1'b0; r.steps = '0; r.period = '0;
        t = x; h = x; met = 0;
        for (int k = 1; k <= MAXS; k++) begin
            h = nf(h);
            if (k % 2 == 1) t = nf(t);
            r.steps = CW'(k);
            if (t == h) begin met = 1; break; end
        end
        if (!met) r.tmo = 1'b1;
        else begin
            met = 0;
            for (int p = 1; p <= MAXS; p++) begin
                h = nf(h);
                r.period = CW'(p);
                if (h == t) begin met = 1; break; end
            end
            if (!met) r.tmo = 1'b1;
        end
        return r;
    endfunction

    // Node array: tortoise moves on the 1st, 3rd, 5th... pulse after a load, hare on every pulse.
    always @(posedge clk) begin
        if (reset_nos) begin
            net_s0 <= init_state;
            net_s1 <= init_state;
            par    <= 1'b0;
        end else begin
            if (start_s0) begin
                if (!par) net_s0 <= nf(net_s0);
                par <= ~par;
            end
            if (start_s1) net_s1 <= nf(net_s1);
        end
    end

    // Monitor and consumer: ready is decided here so the transfer is known before the edge.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_nos) begin
                load_cyc = cyc;
                n_load++;
                chk("strobe_with_load", 64'({start_s0, start_s1}), 64'd0);
            end
            if (done) begin
                n_done++;
                chk("busy_at_done", 64'(busy), 64'd0);
            end
            if (res_valid) begin
                if (!prev_valid) last_lat = cyc - load_cyc;
                chk("strobe_in_report", 64'({reset_nos, start_s0, start_s1}), 64'd0);
                case (rdy_mode)
                    0: res_ready = 1'b1;
                    1: res_ready = 1'($urandom_range(0, 1));
                    default: begin
                        res_ready = (hold == 10);
                        hold = res_ready ? 0 : hold + 1;
                    end
                endcase
                if (res_ready) begin
                    n_res++;
                    chk("res_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("res_init", 64'(res_init), 64'(e.init));
                        chk("res_steps", 64'(res_steps), 64'(e.steps));
                        chk("res_period", 64'(res_period), 64'(e.period));
                        chk("res_timeout", 64'(res_timeout), 64'(e.tmo));
                    end
                end
            end else begin
                res_ready = 1'b0;
                hold = 0;
            end
            prev_valid = res_valid;
        end
    end

    task automatic run(input logic [N-1:0] base, input logic [N-1:0] cnt, input int budget);
        int d0, r0;
        d0 = n_done;
        r0 = n_res;
        for (int i = 0; i < int'(cnt); i++) exp_q.push_back(ref_result(base + N'(i)));
        @(negedge clk);
        init_base  = base;
        init_count = cnt;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < budget && n_done == d0; c++) @(negedge clk);
        chk("done_once", 64'(n_done - d0), 64'd1);
        chk("res_count", 64'(n_res - r0), 64'(cnt));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int l0, d0;
        bit seen;
        for (int i = 0; i < 256; i++) tab[i] = N'($urandom);

        repeat (3) @(negedge clk);
        chk("rst_ctrl", 64'({reset_nos, init_state, start_s0, start_s1, busy, done, res_valid, res_init, res_timeout}), 64'd0);
        chk("rst_steps", 64'(res_steps), 64'd0);
        chk("rst_period", 64'(res_period), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        mode = 0; rdy_mode = 0;
        run(8'd5, 8'd1, 200);
        chk("fixed_pt_latency", 64'(last_lat), 64'd5);

        mode = 1;
        run(8'h01, 8'd1, 200);

        mode = 3; rdy_mode = 2;
        run(N'($urandom), 8'd4, 2000);

        mode = 2; rdy_mode = 0;
        run(8'h00, 8'd1, 500);

        l0 = n_load;
        @(negedge clk);
        init_count = '0;
        init_base  = N'($urandom);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("empty_done_pulse", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk("empty_no_load", 64'(n_load - l0), 64'd0);
        chk("empty_no_valid", 64'(res_valid), 64'd0);

        mode = 3; rdy_mode = 1;
        run(8'hFE, 8'd4, 3000);
        for (int r = 0; r < 6; r++) begin
            mode     = $urandom_range(0, 3);
            rdy_mode = $urandom_range(0, 2);
            run(N'($urandom), N'($urandom_range(1, 4)), 3000);
        end

        mode = 2; rdy_mode = 0;
        d0 = n_done;
        @(negedge clk);
        init_base  = 8'h10;
        init_count = 8'd2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (start_s1 && !start_s0) seen = 1;
        end
        chk("pstep_reached", 64'(seen), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("abort_ctrl", 64'({reset_nos, init_state, start_s0, start_s1, busy, done, res_valid, res_init, res_timeout}), 64'd0);
        chk("abort_steps", 64'(res_steps), 64'd0);
        chk("abort_period", 64'(res_period), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        mode = 0;
        run(8'h33, 8'd1, 200);
        chk("post_abort_latency", 64'(last_lat), 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
